// File: rtl/mem_bus_pkg.sv
// Shared CPU memory-bus definitions: command encoding, MMIO addresses, responder states.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IO_W   = 8;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } resp_state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: synchronous write, registered read with read enable.
module ram_sp #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read share the single address port; read data holds until the next enabled read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: RAM, LED register and synchronised switch port, with a post-reset clearing sweep.
module mem_responder #(
  parameter int unsigned DEPTH      = 256,
  parameter logic [8:0]  LED_ADDR   = mem_bus_pkg::LED_ADDR,
  parameter logic [8:0]  SW_ADDR    = mem_bus_pkg::SW_ADDR,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  input  logic [7:0]  SW,
  output logic [7:0]  LEDR,
  output logic        mem_ready,
  output logic        bad_access
);

  import mem_bus_pkg::*;

  localparam int unsigned       RAM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RAM_AW-1:0] LAST_IDX    = RAM_AW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] RAM_LIMIT   = ADDR_W'(DEPTH);
  localparam resp_state_t       RESET_STATE = INIT_CLEAR ? INIT : READY;

  resp_state_t       state_q, state_d;
  logic [RAM_AW-1:0] cnt_q;
  logic [IO_W-1:0]   sw_meta_q, sw_sync_q;
  logic              rd_from_ram_q;
  logic [DATA_W-1:0] rd_hold_q;
  logic [DATA_W-1:0] ram_rdata;

  logic              in_ram_c;
  logic              ram_we_c, ram_re_c;
  logic [RAM_AW-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              led_we_c, rd_sw_c, rd_bad_c, err_c, cnt_inc_c;

  assign in_ram_c = (mem_addr < RAM_LIMIT);

  // Next-state and bus decode; the sweep owns the RAM port while in INIT.
  always_comb begin
    state_d     = state_q;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_addr_c  = mem_addr[RAM_AW-1:0];
    ram_wdata_c = write_data;
    led_we_c    = 1'b0;
    rd_sw_c     = 1'b0;
    rd_bad_c    = 1'b0;
    err_c       = 1'b0;
    cnt_inc_c   = 1'b0;
    case (state_q)
      INIT: begin
        ram_we_c    = 1'b1;
        ram_addr_c  = cnt_q;
        ram_wdata_c = '0;
        cnt_inc_c   = 1'b1;
        if (cnt_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        case (mem_cmd)
          MREAD: begin
            if (in_ram_c)                ram_re_c = 1'b1;
            else if (mem_addr == SW_ADDR) rd_sw_c = 1'b1;
            else begin
              rd_bad_c = 1'b1;
              err_c    = 1'b1;
            end
          end
          MWRITE: begin
            if (in_ram_c)                  ram_we_c = 1'b1;
            else if (mem_addr == LED_ADDR) led_we_c = 1'b1;
            else                           err_c    = 1'b1;
          end
          MNONE:   ;
          default: err_c = 1'b1;
        endcase
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // Sweep counter, switch synchroniser, read-result source and MMIO/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      rd_from_ram_q <= 1'b0;
      rd_hold_q     <= '0;
      LEDR          <= '0;
      bad_access    <= 1'b0;
      mem_ready     <= 1'b0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      mem_ready <= (state_d == READY);
      if (cnt_inc_c) cnt_q <= cnt_q + RAM_AW'(1);
      if (ram_re_c) rd_from_ram_q <= 1'b1;
      if (rd_sw_c) begin
        rd_from_ram_q <= 1'b0;
        rd_hold_q     <= DATA_W'(sw_sync_q);
      end
      if (rd_bad_c) begin
        rd_from_ram_q <= 1'b0;
        rd_hold_q     <= '0;
      end
      if (led_we_c) LEDR <= write_data[IO_W-1:0];
      if (err_c) bad_access <= 1'b1;
    end
  end

  // Read result comes from the RAM output register or the local hold register.
  assign read_data = rd_from_ram_q ? ram_rdata : rd_hold_q;

  ram_sp #(
    .DEPTH  (DEPTH),
    .ADDR_W (RAM_AW),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: reference RAM/LED/error model, expected reads queued at issue.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  SW;
  logic [7:0]  LEDR;
  logic        mem_ready;
  logic        bad_access;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .SW         (SW),
    .LEDR       (LEDR),
    .mem_ready  (mem_ready),
    .bad_access (bad_access)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [15:0] ram_model [256];
  logic [7:0]  led_exp;
  logic        bad_exp;
  logic [7:0]  sw_exp;
  logic [15:0] exp_q [$];

  // Single comparison point for every check.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) ram_model[i] = 16'h0000;
    led_exp = 8'h00;
    bad_exp = 1'b0;
    exp_q.delete();
  endtask

  // Two reset edges, then release; model returns to its cleared state.
  task automatic reset_dut();
    reset   = 1'b1;
    mem_cmd = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  // Count cycles from reset release until mem_ready; bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!mem_ready && n < 400) begin
      tick();
      n++;
    end
    check(tag, n, 256);
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [15:0] data);
    mem_cmd    = 2'b10;
    mem_addr   = addr;
    write_data = data;
    if (addr < 9'h100)        ram_model[addr[7:0]] = data;
    else if (addr == 9'h100)  led_exp = data[7:0];
    else                      bad_exp = 1'b1;
    tick();
    mem_cmd = 2'b00;
  endtask

  task automatic do_read(input string tag, input logic [8:0] addr);
    logic [15:0] e;
    mem_cmd  = 2'b01;
    mem_addr = addr;
    if (addr < 9'h100)       e = ram_model[addr[7:0]];
    else if (addr == 9'h140) e = {8'h00, sw_exp};
    else begin
      e       = 16'h0000;
      bad_exp = 1'b1;
    end
    exp_q.push_back(e);
    tick();
    mem_cmd = 2'b00;
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check(tag, read_data, exp_q.pop_front());
  endtask

  initial begin
    reset      = 1'b1;
    mem_cmd    = 2'b00;
    mem_addr   = '0;
    write_data = '0;
    SW         = 8'h00;
    sw_exp     = 8'h00;
    clear_model();

    // Reset state and clearing sweep length.
    reset_dut();
    check("rst_read_data", read_data, 16'h0000);
    check("rst_ledr", LEDR, 8'h00);
    check("rst_bad", bad_access, 1'b0);
    check("rst_ready", mem_ready, 1'b0);
    wait_ready("ready_latency");

    do_read("rd_000", 9'h000);
    do_read("rd_07f", 9'h07f);
    do_read("rd_0ff", 9'h0ff);
    check("idle_bad", bad_access, bad_exp);

    // Write followed immediately by read of the same word, value holds afterwards.
    do_write(9'h012, 16'hBEEF);
    do_read("wr_rd_012", 9'h012);
    repeat (3) tick();
    check("hold_012", read_data, 16'hBEEF);
    do_read("rd_013", 9'h013);
    do_write(9'h0ff, 16'h5A5A);
    do_write(9'h000, 16'h0001);
    do_read("rd_0ff_new", 9'h0ff);
    do_read("rd_000_new", 9'h000);

    // LED register and switch port.
    do_write(9'h100, 16'h12A5);
    check("ledr_a5", LEDR, led_exp);
    SW     = 8'h3C;
    sw_exp = 8'h3C;
    repeat (3) tick();
    do_read("sw_3c", 9'h140);
    SW = 8'hC3;
    do_read("sw_sync_lag", 9'h140);
    tick();
    sw_exp = 8'hC3;
    do_read("sw_c3", 9'h140);
    check("mmio_bad", bad_access, 1'b0);

    // Unmapped read sets the sticky flag and zeroes read_data.
    do_read("rd_1ff", 9'h1ff);
    check("bad_1ff", bad_access, bad_exp);
    repeat (5) tick();
    check("bad_sticky", bad_access, 1'b1);
    do_read("rd_after_err", 9'h012);
    check("bad_sticky2", bad_access, 1'b1);

    // Commands during INIT are ignored; mid-sweep reset restarts the sweep.
    reset_dut();
    check("rst2_bad", bad_access, 1'b0);
    for (int c = 1; c <= 100; c++) begin
      mem_cmd = 2'b00;
      if (c == 10) begin mem_cmd = 2'b10; mem_addr = 9'h005; write_data = 16'hFFFF; end
      if (c == 20) begin mem_cmd = 2'b10; mem_addr = 9'h100; write_data = 16'h00FF; end
      if (c == 30) mem_cmd = 2'b11;
      if (c == 40) begin mem_cmd = 2'b01; mem_addr = 9'h1ff; end
      if (c == 99) begin
        check("init_bad", bad_access, 1'b0);
        check("init_ledr", LEDR, 8'h00);
        check("init_ready", mem_ready, 1'b0);
      end
      if (c == 100) reset = 1'b1;
      tick();
    end
    reset   = 1'b0;
    mem_cmd = 2'b00;
    clear_model();
    wait_ready("ready_after_midreset");
    do_read("init_rd_005", 9'h005);
    check("init_ledr_after", LEDR, led_exp);
    check("init_bad_after", bad_access, 1'b0);

    // Reserved command from a clean state.
    mem_cmd = 2'b11;
    tick();
    mem_cmd = 2'b00;
    check("cmd11_bad", bad_access, 1'b1);

    // Write to the read-only switch address flags an error and leaves LEDR alone.
    reset_dut();
    wait_ready("ready_third");
    check("rst3_bad", bad_access, 1'b0);
    do_write(9'h140, 16'h0077);
    check("wr_sw_bad", bad_access, bad_exp);
    check("wr_sw_ledr", LEDR, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
